adc_capture_scheduler: RTL and testbench
========================================

# adc_capture_scheduler

Sequences sample captures for the 8-bit parallel ADC front end: powers the converter up, issues conversion requests at a programmable sample period, counts samples in a burst, buffers captured words in a small FIFO and delivers them over a valid/ready stream. It sits between the system control logic and the per-conversion ADC pin controller. It generates that controller's `ADC_ready` enable and consumes its latched-data strobe.

## Interface
- `WAKE_CYCLES`, 1000, power-up settle time in clocks (10 µs) before the first request
- `TIMEOUT_CYCLES`, 200, maximum clocks from `conv_req` to `conv_done` before abort
- `MIN_PERIOD`, 100, lower clamp on the sample period (one 1 µs conversion frame)
- `FIFO_DEPTH`, 4, sample buffer depth; power of two, ≥2
- `clk_100M`  in  1  system clock, 100 MHz
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse; begins a burst when idle, ignored otherwise
- `stop`  in  1  one-cycle pulse; ends a burst after the conversion in flight
- `burst_len`  in  8  samples per burst, sampled on `start`; 0 = continuous until `stop`
- `period`  in  16  clocks between successive `conv_req`, sampled on `start`
- `keep_on`  in  1  keep the ADC powered after a burst ends
- `adc_pwr_en`  out  1  ADC power enable (high = powered)
- `adc_ready`  out  1  enable to the ADC pin controller
- `conv_req`  out  1  one-cycle conversion request
- `conv_done`  in  1  one-cycle strobe: `sample_in` valid
- `sample_in`  in  8  converted word
- `m_data`  out  8  FIFO head
- `m_valid`  out  1  FIFO non-empty
- `m_ready`  in  1  consumer accepts `m_data` when `m_valid & m_ready`
- `busy`  out  1  high in every state except IDLE
- `overflow`  out  1  sticky; a sample was dropped because the FIFO was full
- `timeout`  out  1  sticky; `conv_done` missed its window

## Operation
- States: IDLE, WAKE, TRIG, WAIT, GAP.
- IDLE:
  - On `start`, latch `burst_len` and `max(period, MIN_PERIOD)`, and clear `overflow` and `timeout`.
  - If `adc_pwr_en` is already 1, go to TRIG. Otherwise set `adc_pwr_en` and go to WAKE.
- WAKE: count `WAKE_CYCLES`, then go to TRIG. `adc_ready` = 1 from the TRIG entry until the return to IDLE.
- TRIG (one cycle):
  - `conv_req` = 1.
  - Restart the period counter and the timeout counter.
  - Go to WAIT.
- WAIT:
  - On `conv_done`, push `sample_in` and decrement the remaining count (continuous mode does not count). Then go to GAP.
  - If `TIMEOUT_CYCLES` elapse first, set `timeout` and go to IDLE; the burst is aborted.
- GAP:
  - If the burst is complete or a stop is pending, go to IDLE.
  - Otherwise go to TRIG when the period counter reaches period−1. If it has already passed, go to TRIG on the next cycle.
- `stop` in any non-IDLE state sets a pending flag, cleared on IDLE entry. `stop` in WAKE goes directly to IDLE.
- IDLE entry: `adc_ready` = 0. `adc_pwr_en` clears unless `keep_on` = 1, or stays as before if still in WAKE.
- The FIFO keeps draining in IDLE. Samples are never discarded on burst end.
- Full FIFO at `conv_done`:
  - If a pop occurs in the same cycle, the push proceeds.
  - Otherwise the sample is dropped and `overflow` is set. The dropped sample still counts toward `burst_len`.
- `conv_done` outside WAIT is ignored.

## Timing
- Reset value: all outputs 0, FSM in IDLE, FIFO empty, sticky flags cleared.
- Reset is honoured in any state, including mid-burst.
- Latency from `start` to first `conv_req`:
  - `WAKE_CYCLES`+2 cycles when powered down.
  - 2 cycles when `adc_pwr_en` is already 1.
- `conv_req` spacing is exactly the effective period while `conv_done` returns within period−2 cycles. Beyond that it is `conv_done`+2.
- FIFO push to `m_valid`: 1 cycle (registered). `m_data` is held stable while `m_valid & !m_ready`.
- Sticky flags assert the cycle after the event.

## Structure
- Shared package `adc_pkg`: state enum, `MIN_PERIOD`, `ADC_DATA_W` = 8.
- Sub-module `adc_sample_fifo`: synchronous FIFO with simultaneous push/pop, plus `full`/`empty` outputs and a count. The scheduler FSM and its counters stay in the top module.

## Test plan
- `start`, `burst_len`=3, `period`=150, ADC model returns `conv_done` 80 cycles after each request → `conv_req` at 1002, 1152, 1302; three words on the stream; `busy` falls after the third `conv_done`; `adc_pwr_en` = 0.
- `period`=10 → spacing clamped to 100 cycles.
- `m_ready` = 0, `burst_len`=6 → 4 words held, `overflow` = 1, burst still ends after 6 `conv_done`s. Then `m_ready` = 1 → the 4 held words drain in order.
- Model never asserts `conv_done` → `timeout` = 1 at request+200+1; FSM returns to IDLE.
- `burst_len`=0, `stop` after 5 requests → exactly 5 samples delivered. With `keep_on` = 1, `adc_pwr_en` stays 1 and the next `start` gives `conv_req` 2 cycles later.
- `reset` pulsed low mid-WAIT → all outputs 0 immediately; FIFO empty after reset release.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared definitions for the ADC capture scheduler: FSM states, data width
// and the minimum sample period.
package adc_pkg;

   localparam int ADC_DATA_W = 8;
   localparam int MIN_PERIOD = 100;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAKE,
      ST_TRIG,
      ST_WAIT,
      ST_GAP
   } state_t;

endpackage

// File: rtl/adc_sample_fifo.sv
// Small synchronous sample FIFO with simultaneous push/pop. A push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module adc_sample_fifo
   import adc_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = ADC_DATA_W
) (
   input  logic                       clk_100M,
   input  logic                       reset,
   input  logic                       push,
   input  logic [W-1:0]               push_data,
   input  logic                       pop,
   output logic [W-1:0]               pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          push_ok;
   logic          pop_ok;

   always_comb begin
      full     = (count_q == (AW+1)'(DEPTH));
      empty    = (count_q == '0);
      push_ok  = push & (~full | pop);
      pop_ok   = pop & ~empty;
      wr_ptr_d = wr_ptr_q + AW'(push_ok);
      rd_ptr_d = rd_ptr_q + AW'(pop_ok);
      count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      // Drive zero while empty so the stream data reads 0 out of reset.
      pop_data = empty ? '0 : mem_q[rd_ptr_q];
      count    = count_q;
   end

   always_ff @(posedge clk_100M or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_100M) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/adc_capture_scheduler.sv
// Burst capture sequencer for the 8-bit parallel ADC: power-up, periodic
// conversion requests, burst counting and a buffered valid/ready output stream.
module adc_capture_scheduler
   import adc_pkg::*;
#(
   parameter int WAKE_CYCLES    = 1000,
   parameter int TIMEOUT_CYCLES = 200,
   parameter int MIN_PERIOD     = adc_pkg::MIN_PERIOD,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                  clk_100M,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  stop,
   input  logic [7:0]            burst_len,
   input  logic [15:0]           period,
   input  logic                  keep_on,
   output logic                  adc_pwr_en,
   output logic                  adc_ready,
   output logic                  conv_req,
   input  logic                  conv_done,
   input  logic [ADC_DATA_W-1:0] sample_in,
   output logic [ADC_DATA_W-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  busy,
   output logic                  overflow,
   output logic                  timeout
);

   localparam int CNT_W = 16;
   localparam int CW    = $clog2(FIFO_DEPTH) + 1;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [15:0]      period_q, period_d;
   logic [7:0]       rem_q, rem_d;
   logic             cont_q, cont_d;
   logic             stop_pend_q, stop_pend_d;
   logic             pwr_en_q, pwr_en_d;
   logic             conv_req_q, conv_req_d;
   logic             overflow_q, overflow_d;
   logic             timeout_q, timeout_d;

   logic             sample_take;
   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CW-1:0]    fifo_count;

   assign fifo_pop   = m_ready & ~fifo_empty;
   assign m_valid    = (fifo_count != '0);
   assign busy       = (state_q != ST_IDLE);
   assign adc_ready  = (state_q == ST_TRIG) || (state_q == ST_WAIT) || (state_q == ST_GAP);
   assign adc_pwr_en = pwr_en_q;
   assign conv_req   = conv_req_q;
   assign overflow   = overflow_q;
   assign timeout    = timeout_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      period_d    = period_q;
      rem_d       = rem_q;
      cont_d      = cont_q;
      stop_pend_d = stop_pend_q;
      pwr_en_d    = pwr_en_q;
      overflow_d  = overflow_q;
      timeout_d   = timeout_q;
      conv_req_d  = 1'b0;
      sample_take = 1'b0;
      cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + 16'd1;

      if (stop && (state_q != ST_IDLE)) begin
         stop_pend_d = 1'b1;
      end

      // One counter serves as both period and timeout timer: both restart on
      // TRIG, and it is preloaded to 1 so GAP releases exactly one period later.
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               rem_d      = burst_len;
               cont_d     = (burst_len == 8'd0);
               period_d   = (period < 16'(MIN_PERIOD)) ? 16'(MIN_PERIOD) : period;
               overflow_d = 1'b0;
               timeout_d  = 1'b0;
               cnt_d      = '0;
               if (pwr_en_q) begin
                  state_d = ST_TRIG;
               end else begin
                  pwr_en_d = 1'b1;
                  state_d  = ST_WAKE;
               end
            end
         end
         ST_WAKE: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (cnt_q == CNT_W'(WAKE_CYCLES - 1)) begin
               state_d = ST_TRIG;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_TRIG: begin
            conv_req_d = 1'b1;
            cnt_d      = 16'd1;
            state_d    = ST_WAIT;
         end
         ST_WAIT: begin
            cnt_d = cnt_inc;
            if (conv_done) begin
               sample_take = 1'b1;
               if (!cont_q) begin
                  rem_d = rem_q - 8'd1;
               end
               if (fifo_full && !fifo_pop) begin
                  overflow_d = 1'b1;
               end
               state_d = ST_GAP;
            end else if (cnt_q >= CNT_W'(TIMEOUT_CYCLES + 1)) begin
               timeout_d = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         ST_GAP: begin
            cnt_d = cnt_inc;
            if ((!cont_q && (rem_q == 8'd0)) || stop_pend_q || stop) begin
               state_d = ST_IDLE;
            end else if (cnt_q >= (period_q - 16'd1)) begin
               state_d = ST_TRIG;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // An aborted wake-up leaves the supply as it was; otherwise keep_on decides.
      if ((state_q != ST_IDLE) && (state_d == ST_IDLE)) begin
         stop_pend_d = 1'b0;
         if (state_q != ST_WAKE) begin
            pwr_en_d = keep_on;
         end
      end
   end

   always_ff @(posedge clk_100M or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         cont_q      <= 1'b0;
         stop_pend_q <= 1'b0;
         pwr_en_q    <= 1'b0;
         conv_req_q  <= 1'b0;
         overflow_q  <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cont_q      <= cont_d;
         stop_pend_q <= stop_pend_d;
         pwr_en_q    <= pwr_en_d;
         conv_req_q  <= conv_req_d;
         overflow_q  <= overflow_d;
         timeout_q   <= timeout_d;
      end
   end

   always_ff @(posedge clk_100M) begin
      period_q <= period_d;
      rem_q    <= rem_d;
   end

   adc_sample_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (ADC_DATA_W)
   ) u_fifo (
      .clk_100M  (clk_100M),
      .reset     (reset),
      .push      (sample_take),
      .push_data (sample_in),
      .pop       (fifo_pop),
      .pop_data  (m_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_adc_capture_scheduler.sv
// Scoreboard bench for adc_capture_scheduler: random ADC responses and stream
// backpressure checked against a queue-based model of the delivered samples.
module tb_adc_capture_scheduler;

   localparam int DEPTH = 4;

   logic       clk_100M = 1'b0;
   logic       reset;
   logic       start;
   logic       stop;
   logic [7:0] burst_len;
   logic [15:0] period;
   logic       keep_on;
   logic       adc_pwr_en;
   logic       adc_ready;
   logic       conv_req;
   logic       conv_done;
   logic [7:0] sample_in;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;
   logic       busy;
   logic       overflow;
   logic       timeout;

   adc_capture_scheduler #(
      .WAKE_CYCLES    (1000),
      .TIMEOUT_CYCLES (200),
      .MIN_PERIOD     (100),
      .FIFO_DEPTH     (DEPTH)
   ) dut (
      .clk_100M   (clk_100M),
      .reset      (reset),
      .start      (start),
      .stop       (stop),
      .burst_len  (burst_len),
      .period     (period),
      .keep_on    (keep_on),
      .adc_pwr_en (adc_pwr_en),
      .adc_ready  (adc_ready),
      .conv_req   (conv_req),
      .conv_done  (conv_done),
      .sample_in  (sample_in),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .busy       (busy),
      .overflow   (overflow),
      .timeout    (timeout)
   );

   always #5 clk_100M = ~clk_100M;

   int cyc = 0;
   always @(posedge clk_100M) cyc <= cyc + 1;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         if (n_fail <= 30)
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ADC model: answers each request after a random delay with a random word.
   bit adc_mute = 1'b0;
   int dmin = 80;
   int dmax = 80;
   initial begin
      conv_done = 1'b0;
      sample_in = '0;
      forever begin
         @(negedge clk_100M);
         if (reset && conv_req && !adc_mute) begin
            repeat (int'($urandom_range(dmax, dmin))) @(posedge clk_100M);
            #1;
            conv_done = 1'b1;
            sample_in = 8'($urandom);
            @(posedge clk_100M);
            #1;
            conv_done = 1'b0;
         end
      end
   end

   // Consumer: 0 = stalled, 1 = always ready, 2 = random backpressure.
   int rdy_mode = 1;
   initial begin
      m_ready = 1'b1;
      forever begin
         @(posedge clk_100M);
         #1;
         case (rdy_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = 1'($urandom_range(1, 0));
         endcase
      end
   end

   // Scoreboard: samples accepted into the buffer are queued at conv_done and
   // popped/compared when the stream hands a word over.
   logic [7:0] exp_q[$];
   int req_q[$];
   int done_cnt  = 0;
   int last_done = 0;
   int pop_cnt   = 0;
   int drop_cnt  = 0;
   int occ;
   bit pop_now;

   always @(negedge clk_100M) begin
      if (!reset) begin
         exp_q.delete();
      end else begin
         pop_now = m_valid && m_ready;
         occ     = exp_q.size();
         chk("m_valid vs buffered words", int'(m_valid), int'(occ != 0));
         if (pop_now && occ > 0) begin
            chk("stream word order", int'(m_data), int'(exp_q[0]));
            void'(exp_q.pop_front());
            pop_cnt++;
         end
         if (conv_done) begin
            done_cnt++;
            last_done = cyc;
            if (occ < DEPTH || pop_now) exp_q.push_back(sample_in);
            else drop_cnt++;
         end
         if (conv_req) req_q.push_back(cyc);
      end
   end

   int t0;

   task automatic do_start(input int b, input int p);
      @(posedge clk_100M);
      #1;
      burst_len = 8'(b);
      period    = 16'(p);
      start     = 1'b1;
      req_q.delete();
      t0 = cyc;
      @(posedge clk_100M);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_reqs(input int n, input string name);
      for (int i = 0; i < 3000; i++) begin
         if (req_q.size() >= n) break;
         @(negedge clk_100M);
         #1;
      end
      if (req_q.size() < n) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s: saw %0d requests, expected %0d", name, req_q.size(), n);
      end
   endtask

   task automatic wait_idle(output int when, input string name);
      when = -1;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk_100M);
         if (!busy) begin
            when = cyc;
            break;
         end
      end
      if (when < 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s: busy still 1, expected 0 within budget", name);
      end
   endtask

   function automatic int req_at(input int i);
      return (req_q.size() > i) ? req_q[i] : -100000;
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int idle_at, p, base_done, base_pop, base_drop, to_cyc, r;
      reset     = 1'b1;
      start     = 1'b0;
      stop      = 1'b0;
      burst_len = '0;
      period    = '0;
      keep_on   = 1'b0;
      #3 reset = 1'b0;
      repeat (3) @(posedge clk_100M);
      #1;
      chk("reset adc_pwr_en", int'(adc_pwr_en), 0);
      chk("reset adc_ready", int'(adc_ready), 0);
      chk("reset conv_req", int'(conv_req), 0);
      chk("reset m_valid", int'(m_valid), 0);
      chk("reset m_data", int'(m_data), 0);
      chk("reset busy", int'(busy), 0);
      chk("reset overflow", int'(overflow), 0);
      chk("reset timeout", int'(timeout), 0);
      reset = 1'b1;

      // Three-sample burst from power-down, 80-cycle conversions.
      dmin = 80; dmax = 80;
      do_start(3, 150);
      wait_reqs(3, "t1 requests");
      chk("t1 req0 latency", req_at(0) - t0, 1002);
      chk("t1 req1 latency", req_at(1) - t0, 1152);
      chk("t1 req2 latency", req_at(2) - t0, 1302);
      wait_idle(idle_at, "t1 idle");
      chk("t1 busy fall after last done", idle_at - last_done, 2);
      chk("t1 adc_pwr_en off", int'(adc_pwr_en), 0);
      chk("t1 adc_ready off", int'(adc_ready), 0);
      repeat (5) @(posedge clk_100M);
      chk("t1 words delivered", pop_cnt, 3);

      // Period below the minimum is clamped; keep_on holds the supply.
      keep_on = 1'b1;
      dmin = 5; dmax = 60;
      do_start(3, 10);
      wait_reqs(3, "t2 requests");
      chk("t2 req0 latency", req_at(0) - t0, 1002);
      chk("t2 spacing 0-1", req_at(1) - req_at(0), 100);
      chk("t2 spacing 1-2", req_at(2) - req_at(1), 100);
      wait_idle(idle_at, "t2 idle");
      chk("t2 adc_pwr_en held", int'(adc_pwr_en), 1);

      // Stalled consumer: four words held, two dropped, burst still ends.
      keep_on = 1'b0;
      rdy_mode = 0;
      repeat (3) @(posedge clk_100M);
      dmin = 3; dmax = 40;
      p = int'($urandom_range(130, 100));
      base_done = done_cnt;
      base_pop  = pop_cnt;
      do_start(6, p);
      wait_reqs(6, "t3 requests");
      chk("t3 req0 latency powered", req_at(0) - t0, 2);
      for (int i = 0; i < 5; i++)
         chk("t3 spacing", req_at(i + 1) - req_at(i), p);
      wait_idle(idle_at, "t3 idle");
      chk("t3 conv_done count", done_cnt - base_done, 6);
      chk("t3 overflow", int'(overflow), 1);
      chk("t3 m_valid held", int'(m_valid), 1);
      chk("t3 adc_pwr_en off", int'(adc_pwr_en), 0);
      rdy_mode = 1;
      repeat (10) @(posedge clk_100M);
      chk("t3 words drained", pop_cnt - base_pop, 4);
      @(negedge clk_100M);
      chk("t3 drained m_valid", int'(m_valid), 0);

      // Silent ADC: timeout one cycle after the window closes.
      adc_mute = 1'b1;
      do_start(2, 100);
      repeat (3) @(posedge clk_100M);
      @(negedge clk_100M);
      chk("t4 start clears overflow", int'(overflow), 0);
      wait_reqs(1, "t4 request");
      r = req_at(0);
      to_cyc = -1;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk_100M);
         if (timeout) begin
            to_cyc = cyc;
            break;
         end
      end
      chk("t4 timeout cycle", to_cyc - r, 201);
      chk("t4 busy after timeout", int'(busy), 0);
      repeat (5) @(posedge clk_100M);
      chk("t4 single request", req_q.size(), 1);
      adc_mute = 1'b0;

      // Continuous mode with stop and random backpressure.
      keep_on = 1'b1;
      rdy_mode = 2;
      dmin = 10; dmax = 50;
      p = int'($urandom_range(200, 100));
      base_done = done_cnt;
      base_pop  = pop_cnt;
      base_drop = drop_cnt;
      do_start(0, p);
      repeat (3) @(posedge clk_100M);
      @(negedge clk_100M);
      chk("t5 start clears timeout", int'(timeout), 0);
      wait_reqs(5, "t5 requests");
      @(posedge clk_100M);
      #1 stop = 1'b1;
      @(posedge clk_100M);
      #1 stop = 1'b0;
      wait_idle(idle_at, "t5 idle");
      chk("t5 request count", req_q.size(), 5);
      chk("t5 spacing", req_at(4) - req_at(3), p);
      chk("t5 conv_done count", done_cnt - base_done, 5);
      rdy_mode = 1;
      repeat (10) @(posedge clk_100M);
      chk("t5 words delivered", pop_cnt - base_pop, 5 - (drop_cnt - base_drop));
      chk("t5 adc_pwr_en held", int'(adc_pwr_en), 1);
      do_start(1, 100);
      wait_reqs(1, "t5 restart request");
      chk("t5 restart latency", req_at(0) - t0, 2);
      wait_idle(idle_at, "t5 restart idle");
      repeat (10) @(posedge clk_100M);

      // Reset mid-WAIT with words buffered.
      rdy_mode = 0;
      dmin = 20; dmax = 20;
      do_start(2, 100);
      wait_reqs(2, "t6 requests");
      wait_idle(idle_at, "t6 idle");
      chk("t6 words buffered", int'(m_valid), 1);
      adc_mute = 1'b1;
      do_start(1, 100);
      wait_reqs(1, "t6 muted request");
      repeat (10) @(posedge clk_100M);
      #1 reset = 1'b0;
      #1;
      chk("t6 reset busy", int'(busy), 0);
      chk("t6 reset adc_pwr_en", int'(adc_pwr_en), 0);
      chk("t6 reset adc_ready", int'(adc_ready), 0);
      chk("t6 reset conv_req", int'(conv_req), 0);
      chk("t6 reset m_valid", int'(m_valid), 0);
      chk("t6 reset m_data", int'(m_data), 0);
      repeat (2) @(posedge clk_100M);
      #1 reset = 1'b1;
      @(negedge clk_100M);
      chk("t6 post-reset m_valid", int'(m_valid), 0);
      chk("t6 post-reset busy", int'(busy), 0);
      adc_mute = 1'b0;
      rdy_mode = 1;
      keep_on  = 1'b0;
      dmin = 30; dmax = 30;
      do_start(1, 100);
      wait_reqs(1, "t6 recovery request");
      chk("t6 recovery latency", req_at(0) - t0, 1002);
      wait_idle(idle_at, "t6 recovery idle");
      repeat (5) @(posedge clk_100M);
      chk("t6 scoreboard empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
